// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencing controller:
// FSM state encodings, HI/LO source select, legacy handshake constants and
// the op decoder.
package mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // Which value is loaded into the HI/LO result register this cycle.
  typedef enum logic [1:0] {
    HILO_NONE    = 2'd0,
    HILO_MUL     = 2'd1,
    HILO_DIV     = 2'd2,
    HILO_DIVZERO = 2'd3
  } hilo_src_e;

  // Constants carried over from the original EX-stage sequencing.
  localparam logic Stop           = 1'b1;
  localparam logic NoStop         = 1'b0;
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  // Multiplier latency countdown width (MUL_LATENCY is 1..4).
  localparam int CNT_W = 3;

  typedef struct packed {
    logic valid;   // some mult/div op is present
    logic is_div;  // div/divu rather than mult/multu
    logic sgn;     // signed variant
  } mdu_op_t;

  // One-hot op decode; if several are asserted, div > divu > mult > multu.
  function automatic mdu_op_t decode_op(input logic mult, input logic multu,
                                        input logic div,  input logic divu);
    mdu_op_t op;
    op = '{valid: 1'b0, is_div: 1'b0, sgn: 1'b0};
    if (div)        op = '{valid: 1'b1, is_div: 1'b1, sgn: 1'b1};
    else if (divu)  op = '{valid: 1'b1, is_div: 1'b1, sgn: 1'b0};
    else if (mult)  op = '{valid: 1'b1, is_div: 1'b0, sgn: 1'b1};
    else if (multu) op = '{valid: 1'b1, is_div: 1'b0, sgn: 1'b0};
    return op;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences one mult/multu/div/divu per issue through the clocked
// multiplier and the iterative divider, stalls the pipeline until the 64-bit
// result is ready, then presents a HI/LO write.
// Optional feature macro: MDU_DIVZERO_FAST_EN (divide-by-zero bypasses the
// divider and writes {rs, 32'hFFFF_FFFF} directly).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        inst_mult,
  input  logic        inst_multu,
  input  logic        inst_div,
  input  logic        inst_divu,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        stallreq_for_mdu,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  mdu_state_e       state_q, state_d;
  logic [31:0]      op_a_q, op_b_q;
  logic             sgn_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;

  mdu_op_t          op;
  logic             capture;
  logic             div_zero_fast;
  hilo_src_e        hilo_src;

  assign op = decode_op(inst_mult, inst_multu, inst_div, inst_divu);

`ifdef MDU_DIVZERO_FAST_EN
  assign div_zero_fast = op.is_div && (rf_rdata2 == 32'd0);
`else
  assign div_zero_fast = 1'b0;
`endif

  // Next-state, handshake and stall decode for the current state.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d          = state_q;
    capture          = 1'b0;
    hilo_src         = HILO_NONE;
    stallreq_for_mdu = NoStop;
    hilo_we          = 1'b0;
    div_start        = DivStop;
    div_annul        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        MDU_IDLE: begin
          if (op.valid && !flush) begin
            stallreq_for_mdu = Stop;
            capture          = 1'b1;
            if (!op.is_div) begin
              state_d = MDU_MUL;
            end else if (div_zero_fast) begin
              state_d  = MDU_DONE;
              hilo_src = HILO_DIVZERO;
            end else begin
              state_d = MDU_DIV;
            end
          end
        end
        MDU_MUL: begin
          stallreq_for_mdu = Stop;
          if (flush) begin
            state_d = MDU_IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            state_d  = MDU_DONE;
            hilo_src = HILO_MUL;
          end
        end
        MDU_DIV: begin
          stallreq_for_mdu = Stop;
          if (flush) begin
            // The divider is cancelled rather than left running on a dead op.
            div_annul = 1'b1;
            state_d   = MDU_IDLE;
          end else begin
            div_start = (div_ready == DivResultReady) ? DivStop : DivStart;
            if (div_ready == DivResultReady) begin
              state_d  = MDU_DONE;
              hilo_src = HILO_DIV;
            end
          end
        end
        MDU_DONE: begin
          // The op still on the inputs here is the one just completed, so it
          // is deliberately ignored until the pipeline moves past it.
          if (flush) begin
            state_d = MDU_IDLE;
          end else begin
            hilo_we = 1'b1;
            if (!ex_stall) state_d = MDU_IDLE;
          end
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  // State, captured operands, latency counter and HI/LO result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= MDU_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        op_a_q <= rf_rdata1;
        op_b_q <= rf_rdata2;
        sgn_q  <= op.sgn;
        cnt_q  <= CNT_W'(MUL_LATENCY);
      end else if (state_q == MDU_MUL) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      unique case (hilo_src)
        HILO_MUL:     {hi_q, lo_q} <= mul_result;
        HILO_DIV:     {hi_q, lo_q} <= div_result;
        HILO_DIVZERO: {hi_q, lo_q} <= {rf_rdata1, 32'hFFFF_FFFF};
        default:      ;
      endcase
    end
  end

  // Engines always see the captured operands.
  assign mul_ina     = op_a_q;
  assign mul_inb     = op_b_q;
  assign mul_signed  = sgn_q;
  assign div_opdata1 = op_a_q;
  assign div_opdata2 = op_b_q;
  assign div_signed  = sgn_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with simple multiplier and divider models.
// Expected HI/LO values are hand-computed constants.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, ex_stall;
  logic        inst_mult, inst_multu, inst_div, inst_divu;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        stallreq_for_mdu, hilo_we;
  logic [31:0] hi_o, lo_o;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        div_ready;

  int checks   = 0;
  int failures = 0;
  int div_lat  = 33;
  int div_cnt  = 0;

  mdu_ctrl #(.MUL_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .inst_mult(inst_mult), .inst_multu(inst_multu),
    .inst_div(inst_div), .inst_divu(inst_divu),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .stallreq_for_mdu(stallreq_for_mdu), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: 64-bit product of the (sign- or zero-) extended inputs.
  always_comb begin
    logic [63:0] ea, eb;
    ea = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
    eb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
    mul_result = ea * eb;
  end

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = int'(a);
      sb = int'(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Iterative divider model: ready div_lat cycles after start rises.
  always @(posedge clk) begin
    if (rst || div_annul || !div_start) begin
      div_cnt   <= 0;
      div_ready <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1;
      if (div_cnt + 1 == div_lat) begin
        div_ready  <= 1'b1;
        div_result <= div_model(div_signed, div_opdata1, div_opdata2);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 2 time units after the edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  // op bits: {div, divu, mult, multu}
  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    {inst_div, inst_divu, inst_mult, inst_multu} = op;
    rf_rdata1 = a;
    rf_rdata2 = b;
  endtask

  // Wait (bounded) for div_ready; stall must stay asserted while waiting.
  task automatic wait_ready(input string tag, output int waited);
    logic stall_ok;
    stall_ok = 1'b1;
    waited   = 0;
    while (div_ready !== 1'b1 && waited < 200) begin
      stall_ok &= stallreq_for_mdu;
      cycle();
      waited++;
    end
    check({tag, "_ready_seen"}, 64'(div_ready), 64'd1);
    check({tag, "_stall_held"}, 64'(stall_ok & stallreq_for_mdu), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    div_result = '0;
    set_op(4'b0010, 32'hFFFF_FFFE, 32'd3);
    cycle();
    cycle();
    check("rst_stall", 64'(stallreq_for_mdu), 64'd0);
    check("rst_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_mul_ina", 64'(mul_ina), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);

    // mult -2 * 3: stall two cycles, write in the third.
    rst = 1'b0; #1;
    check("mult_issue_stall", 64'(stallreq_for_mdu), 64'd1);
    check("mult_issue_we", 64'(hilo_we), 64'd0);
    cycle();
    check("mult_mul_stall", 64'(stallreq_for_mdu), 64'd1);
    check("mult_mul_ops", {mul_ina, mul_inb}, {32'hFFFF_FFFE, 32'd3});
    check("mult_mul_signed", 64'(mul_signed), 64'd1);
    cycle();
    check("mult_done_stall", 64'(stallreq_for_mdu), 64'd0);
    check("mult_done_we", 64'(hilo_we), 64'd1);
    check("mult_done_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    // Back-to-back multu 0xFFFFFFFF * 2, with ex_stall held in DONE 3 cycles.
    cycle();
    set_op(4'b0001, 32'hFFFF_FFFF, 32'd2); #1;
    check("b2b_issue_stall", 64'(stallreq_for_mdu), 64'd1);
    check("b2b_issue_we", 64'(hilo_we), 64'd0);
    cycle();
    check("multu_signed", 64'(mul_signed), 64'd0);
    cycle();
    ex_stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("exstall_we", 64'(hilo_we), 64'd1);
      check("exstall_no_reissue", 64'(stallreq_for_mdu), 64'd0);
      check("exstall_hilo", {hi_o, lo_o}, {32'd1, 32'hFFFF_FFFE});
      cycle();
    end
    ex_stall = 1'b0; #1;
    check("exstall_we_4th", 64'(hilo_we), 64'd1);
    cycle();
    set_op(4'b0000, 32'd0, 32'd0); #1;
    check("exstall_idle_we", 64'(hilo_we), 64'd0);
    check("exstall_idle_stall", 64'(stallreq_for_mdu), 64'd0);

    // divu 100 / 7 with a 33-cycle divider.
    div_lat = 33;
    cycle();
    set_op(4'b0100, 32'd100, 32'd7); #1;
    check("divu_issue_stall", 64'(stallreq_for_mdu), 64'd1);
    check("divu_issue_start", 64'(div_start), 64'd0);
    cycle();
    check("divu_start", 64'(div_start), 64'd1);
    check("divu_signed", 64'(div_signed), 64'd0);
    check("divu_ops", {div_opdata1, div_opdata2}, {32'd100, 32'd7});
    wait_ready("divu", n);
    check("divu_latency", 64'(n), 64'd33);
    check("divu_ready_start", 64'(div_start), 64'd0);
    check("divu_ready_we", 64'(hilo_we), 64'd0);
    cycle();
    check("divu_done_we", 64'(hilo_we), 64'd1);
    check("divu_done_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
    check("divu_done_stall", 64'(stallreq_for_mdu), 64'd0);
    cycle();
    set_op(4'b0000, 32'd0, 32'd0); #1;
    check("divu_idle_we", 64'(hilo_we), 64'd0);

    // div -7 / 2 flushed at cycle 10 of the operation.
    cycle();
    set_op(4'b1000, 32'hFFFF_FFF9, 32'd2); #1;
    check("flush_issue_stall", 64'(stallreq_for_mdu), 64'd1);
    cycle();
    check("flush_div_signed", 64'(div_signed), 64'd1);
    repeat (9) cycle();
    flush = 1'b1; #1;
    check("flush_annul", 64'(div_annul), 64'd1);
    check("flush_we", 64'(hilo_we), 64'd0);
    cycle();
    flush = 1'b0;
    set_op(4'b0000, 32'd0, 32'd0); #1;
    check("flush_after_annul", 64'(div_annul), 64'd0);
    check("flush_after_stall", 64'(stallreq_for_mdu), 64'd0);
    check("flush_after_start", 64'(div_start), 64'd0);
    check("flush_after_we", 64'(hilo_we), 64'd0);
    cycle();
    check("flush_after2_we", 64'(hilo_we), 64'd0);

    // divu 20 / 3 where flush coincides with div_ready.
    div_lat = 5;
    set_op(4'b0100, 32'd20, 32'd3); #1;
    cycle();
    wait_ready("rdyflush", n);
    flush = 1'b1; #1;
    check("rdyflush_annul", 64'(div_annul), 64'd1);
    check("rdyflush_we", 64'(hilo_we), 64'd0);
    cycle();
    flush = 1'b0;
    set_op(4'b0000, 32'd0, 32'd0); #1;
    check("rdyflush_next_we", 64'(hilo_we), 64'd0);
    check("rdyflush_next_stall", 64'(stallreq_for_mdu), 64'd0);
    cycle();
    check("rdyflush_next2_we", 64'(hilo_we), 64'd0);

    // div 0x1234 / 0.
    set_op(4'b1000, 32'h0000_1234, 32'd0); #1;
    check("divzero_issue_stall", 64'(stallreq_for_mdu), 64'd1);
    cycle();
`ifdef MDU_DIVZERO_FAST_EN
    check("divzero_fast_start", 64'(div_start), 64'd0);
    check("divzero_fast_stall", 64'(stallreq_for_mdu), 64'd0);
`else
    check("divzero_start", 64'(div_start), 64'd1);
    wait_ready("divzero", n);
    cycle();
`endif
    check("divzero_we", 64'(hilo_we), 64'd1);
    check("divzero_hilo", {hi_o, lo_o}, {32'h0000_1234, 32'hFFFF_FFFF});
    cycle();
    set_op(4'b0000, 32'd0, 32'd0); #1;

    // div and mult together: div wins; then reset mid-operation.
    div_lat = 33;
    cycle();
    set_op(4'b1010, 32'd9, 32'd4); #1;
    cycle();
    check("prio_div_start", 64'(div_start), 64'd1);
    check("prio_div_signed", 64'(div_signed), 64'd1);
    cycle();
    rst = 1'b1; #1;
    check("midrst_annul", 64'(div_annul), 64'd0);
    check("midrst_stall", 64'(stallreq_for_mdu), 64'd0);
    cycle();
    rst = 1'b0;
    set_op(4'b0000, 32'd0, 32'd0); #1;
    check("midrst_idle_stall", 64'(stallreq_for_mdu), 64'd0);
    check("midrst_idle_start", 64'(div_start), 64'd0);
    check("midrst_idle_we", 64'(hilo_we), 64'd0);
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
